rotor_ctrl: RTL and testbench

- Initiator-side sequencer for one rotor stage of the cipher datapath. It accepts plaintext or ciphertext characters on a valid/ready stream and drives the rotor's configuration, load, step and direction inputs.
- It waits for the rotor's done, captures the rotor output and presents it on a valid/ready output stream.
- Non-letter characters bypass the rotor unchanged.

---
 rtl/rotor_ctrl_if.sv | 35 +++
 rtl/rotor_ctrl.sv | 158 +++++++++++++++
 tb/tb_rotor_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotor_ctrl_if.sv
// Stream and rotor-side signal bundle for rotor_ctrl.
// master = controller side, slave = character source/sink and rotor.
`timescale 1ns/1ps
interface rotor_ctrl_if #(
  parameter int CW = 8
) ();
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_char;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_char;
  logic          r_set;
  logic [31:0]   r_offset;
  logic [31:0]   r_delay;
  logic [207:0]  r_idx;
  logic          r_dec;
  logic          r_valid;
  logic [CW-1:0] r_din;
  logic          r_en;
  logic [CW-1:0] r_dout;
  logic          r_done;

  modport master (
    input  in_valid, in_char, out_ready, r_dout, r_done,
    output in_ready, out_valid, out_char,
           r_set, r_offset, r_delay, r_idx, r_dec, r_valid, r_din, r_en
  );

  modport slave (
    output in_valid, in_char, out_ready, r_dout, r_done,
    input  in_ready, out_valid, out_char,
           r_set, r_offset, r_delay, r_idx, r_dec, r_valid, r_din, r_en
  );
endinterface

// File: rtl/rotor_ctrl.sv
// Sequencer for one rotor stage: config strobe, load/step pulses, timed wait
// for r_done, output hold. Optional char_cnt port under `ROTOR_CTRL_CNT_EN`.
`timescale 1ns/1ps
module rotor_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_load,
  input  logic [31:0]   cfg_offset,
  input  logic [31:0]   cfg_delay,
  input  logic [207:0]  cfg_idx,
  input  logic          cfg_dec,
  rotor_ctrl_if.master  bus,
  output logic          busy,
  output logic          err
`ifdef ROTOR_CTRL_CNT_EN
  ,
  output logic [15:0]   char_cnt
`endif
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD,
    S_STEP,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  function automatic logic is_letter(input logic [CW-1:0] c);
    return (c >= CW'(8'h41)) && (c <= CW'(8'h5A));
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
      bus.in_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_char <= '0;
      bus.r_set    <= 1'b0;
      bus.r_offset <= '0;
      bus.r_delay  <= '0;
      bus.r_idx    <= '0;
      bus.r_dec    <= 1'b0;
      bus.r_valid  <= 1'b0;
      bus.r_din    <= '0;
      bus.r_en     <= 1'b0;
`ifdef ROTOR_CTRL_CNT_EN
      char_cnt     <= '0;
`endif
    end else begin
      // strobes default low so each lasts exactly one cycle
      bus.r_set   <= 1'b0;
      bus.r_valid <= 1'b0;
      bus.r_en    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            bus.r_offset <= cfg_offset;
            bus.r_delay  <= cfg_delay;
            bus.r_idx    <= cfg_idx;
            bus.r_dec    <= cfg_dec;
            bus.r_set    <= 1'b1;
            err          <= 1'b0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= S_CFG;
`ifdef ROTOR_CTRL_CNT_EN
            char_cnt     <= '0;
`endif
          end else if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            if (is_letter(bus.in_char)) begin
              bus.r_din   <= bus.in_char;
              bus.r_valid <= 1'b1;
              state       <= S_LOAD;
            end else begin
              bus.out_char  <= bus.in_char;
              bus.out_valid <= 1'b1;
              state         <= S_HOLD;
            end
          end else begin
            // in_ready comes up on the first cycle after reset release
            bus.in_ready <= 1'b1;
          end
        end

        S_CFG: begin
          bus.in_ready <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end

        S_LOAD: begin
          bus.r_en <= 1'b1;
          state    <= S_STEP;
        end

        S_STEP: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          // r_done wins over the timeout on the final count
          if (bus.r_done) begin
            bus.out_char  <= bus.r_dout;
            bus.out_valid <= 1'b1;
            state         <= S_HOLD;
          end else if (wait_cnt == CNT_LAST) begin
            err          <= 1'b1;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= S_IDLE;
`ifdef ROTOR_CTRL_CNT_EN
            if (char_cnt != 16'hFFFF) begin
              char_cnt <= char_cnt + 16'd1;
            end
`endif
          end
        end

        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotor_ctrl.sv
// Bench for rotor_ctrl: directed vector table, hand sequences for reset,
// config priority and mid-flight reset, then random traffic against a model.
`timescale 1ns/1ps
module tb_rotor_ctrl;
  localparam int CW = 8;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cfg_load;
  logic [31:0]  cfg_offset;
  logic [31:0]  cfg_delay;
  logic [207:0] cfg_idx;
  logic         cfg_dec;
  logic         busy;
  logic         err;
`ifdef ROTOR_CTRL_CNT_EN
  logic [15:0]  char_cnt;
`endif

  rotor_ctrl_if #(.CW(CW)) bus ();

  rotor_ctrl #(.TIMEOUT(TO), .CW(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_load   (cfg_load),
    .cfg_offset (cfg_offset),
    .cfg_delay  (cfg_delay),
    .cfg_idx    (cfg_idx),
    .cfg_dec    (cfg_dec),
    .bus        (bus),
    .busy       (busy),
    .err        (err)
`ifdef ROTOR_CTRL_CNT_EN
    ,
    .char_cnt   (char_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] wiring [26];
  bit  err_exp = 1'b0;
  int  cnt_exp = 0;
  int  resp_lat = -1;
  int  n_rvalid = 0;
  int  n_ren    = 0;
  int  n_rset   = 0;

  typedef struct {
    logic [7:0] ch;
    int         lat;
    int         rdly;
    logic [7:0] exp_char;
    bit         exp_out;
  } vec_t;
  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_alpha(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic logic [7:0] ref_out(input logic [7:0] c);
    if (is_alpha(c)) return wiring[c - 8'h41];
    return c;
  endfunction

  // pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (bus.r_valid === 1'b1) n_rvalid++;
    if (bus.r_en === 1'b1)    n_ren++;
    if (bus.r_set === 1'b1)   n_rset++;
  end

  // rotor stand-in: answers through the configured wiring table after resp_lat WAIT cycles
  initial begin
    bus.r_done = 1'b0;
    bus.r_dout = 8'hEE;
    forever begin
      @(posedge clk);
      #1;
      if (bus.r_en === 1'b1 && resp_lat >= 0) begin
        int l;
        logic [7:0] c;
        int idx;
        l   = resp_lat;
        c   = bus.r_din;
        idx = int'(c) - 65;
        if (idx < 0 || idx > 25) idx = 0;
        repeat (l + 1) @(posedge clk);
        #1;
        bus.r_done = 1'b1;
        bus.r_dout = bus.r_idx[207 - 8*idx -: 8];
        @(posedge clk);
        #1;
        bus.r_done = 1'b0;
        bus.r_dout = 8'hEE;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_cfg(input logic [31:0] off, input logic [31:0] dly, input logic dec,
                        input bit with_char);
    int rv0;
    rv0 = n_rvalid;
    cfg_offset = off; cfg_delay = dly; cfg_dec = dec; cfg_load = 1'b1;
    if (with_char) begin bus.in_valid = 1'b1; bus.in_char = 8'h41; end
    tick();
    cfg_load = 1'b0; bus.in_valid = 1'b0;
    chk("cfg_r_set", bus.r_set, 1);
    chk("cfg_r_offset", bus.r_offset, off);
    chk("cfg_r_delay", bus.r_delay, dly);
    chk("cfg_r_dec", bus.r_dec, dec);
    chk("cfg_r_idx", bus.r_idx == cfg_idx, 1);
    chk("cfg_in_ready", bus.in_ready, 0);
    chk("cfg_busy", busy, 1);
    chk("cfg_err_clr", err, 0);
    tick();
    chk("cfg_r_set_once", bus.r_set, 0);
    chk("cfg_back_idle", bus.in_ready, 1);
    chk("cfg_no_load", n_rvalid - rv0, 0);
    chk("cfg_no_out", bus.out_valid, 0);
    err_exp = 1'b0;
    cnt_exp = 0;
  endtask

  task automatic run_char(input logic [7:0] ch, input int lat, input int rdly,
                          input logic [7:0] exp_char, input bit exp_out);
    bit letter;
    int n;
    int rv0;
    int re0;
    letter = is_alpha(ch);
    rv0 = n_rvalid;
    re0 = n_ren;
    resp_lat = lat;
    chk("idle_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_char = ch;
    tick();
    bus.in_valid = 1'b0; bus.in_char = 8'h00;
    chk("accept_busy", busy, 1);
    chk("accept_ready_low", bus.in_ready, 0);
    if (letter) begin
      chk("load_r_valid", bus.r_valid, 1);
      chk("load_r_din", bus.r_din, ch);
      tick();
      chk("step_r_en", bus.r_en, 1);
      chk("step_r_valid_low", bus.r_valid, 0);
      chk("step_r_din", bus.r_din, ch);
      tick();
      n = 0;
      while (bus.out_valid !== 1'b1 && busy === 1'b1 && n < TO + 10) begin
        tick();
        n++;
      end
      if (exp_out) begin
        chk("done_latency", n, lat + 1);
      end else begin
        chk("timeout_cycles", n, TO);
        chk("timeout_err", err, 1);
        chk("timeout_no_out", bus.out_valid, 0);
        chk("timeout_idle", bus.in_ready, 1);
        err_exp = 1'b1;
      end
    end
    if (exp_out) begin
      chk("out_valid", bus.out_valid, 1);
      chk("out_char", bus.out_char, exp_char);
      for (int k = 0; k < rdly; k++) begin
        tick();
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_char", bus.out_char, exp_char);
        chk("bp_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("hs_valid_low", bus.out_valid, 0);
      chk("hs_idle", bus.in_ready, 1);
      chk("hs_busy", busy, 0);
      if (cnt_exp < 16'hFFFF) cnt_exp = cnt_exp + 1;
    end
    chk("r_valid_pulses", n_rvalid - rv0, letter ? 1 : 0);
    chk("r_en_pulses", n_ren - re0, letter ? 1 : 0);
    chk("err_state", err, err_exp);
`ifdef ROTOR_CTRL_CNT_EN
    chk("char_cnt", char_cnt, cnt_exp);
`endif
  endtask

  initial begin
    logic [7:0] ch;
    int lat;
    cfg_load = 1'b0; cfg_offset = '0; cfg_delay = '0; cfg_idx = '0; cfg_dec = 1'b0;
    bus.in_valid = 1'b0; bus.in_char = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 26; i++) begin
      wiring[i] = 8'(65 + (i + 1) % 26);
      cfg_idx[207 - 8*i -: 8] = wiring[i];
    end

    vt[0] = '{8'h41, 3, 0, 8'h42, 1'b1};
    vt[1] = '{8'h20, 0, 0, 8'h20, 1'b1};
    vt[2] = '{8'h5A, 0, 1, 8'h41, 1'b1};
    vt[3] = '{8'h40, 0, 0, 8'h40, 1'b1};
    vt[4] = '{8'h5B, 0, 2, 8'h5B, 1'b1};
    vt[5] = '{8'h4D, TO - 1, 2, 8'h4E, 1'b1};
    vt[6] = '{8'h41, 3, 5, 8'h42, 1'b1};
    vt[7] = '{8'h51, -1, 0, 8'h00, 1'b0};

    // reset held two cycles
    reset_n = 1'b0;
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_r_set", bus.r_set, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_r_offset", bus.r_offset, 0);
    chk("post_rst_out_char", bus.out_char, 0);

    do_cfg(32'd1, 32'd4, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_char(vt[i].ch, vt[i].lat, vt[i].rdly, vt[i].exp_char, vt[i].exp_out);
    end
    // err is sticky across a good character, cleared by cfg_load
    run_char(8'h2E, 0, 0, 8'h2E, 1'b1);
    chk("err_sticky", err, 1);
    do_cfg(32'd7, 32'd9, 1'b1, 1'b1);

    // reset while waiting on the rotor drops the character
    resp_lat = -1;
    bus.in_valid = 1'b1; bus.in_char = 8'h43;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("midop_busy", busy, 1);
    reset_n = 1'b0;
    tick();
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_r_offset", bus.r_offset, 0);
    chk("midop_rst_r_din", bus.r_din, 0);
    reset_n = 1'b1;
    tick();
    chk("midop_in_ready", bus.in_ready, 1);
    tick(); tick();
    chk("midop_no_out", bus.out_valid, 0);
    err_exp = 1'b0;
    cnt_exp = 0;
    do_cfg(32'd1, 32'd4, 1'b0, 1'b0);

    // random traffic against the model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) != 0) ch = 8'(65 + $urandom_range(0, 25));
      else ch = 8'($urandom_range(0, 255));
      lat = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      run_char(ch, lat, int'($urandom_range(0, 3)), ref_out(ch),
               !is_alpha(ch) || lat >= 0);
      if (err_exp && $urandom_range(0, 1) == 0) do_cfg(32'd1, 32'd4, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
